alu_op_sequencer: RTL and testbench

- Multi-cycle control stage directly upstream of the accumulator/ALU datapath.
- Accepts one ALU request per handshake and issues the ALU's control strobes in a fixed order: save Acc, drive operand on the bus, execute, restore Acc.
- Drives the ALU signals `a_store`, `tmp_we`, `cs`, `op` and `a_restore`, and drives the bus through an output enable.
- Supports repeated execution of one op, for example rotate-by-N, so the controller FSM issues one request instead of N.

---
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Control sequencer ahead of the accumulator/ALU datapath: issues save, load,
// execute (optionally repeated) and restore strobes for one request at a time.
module alu_op_sequencer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OP_W   = 5,
   parameter int unsigned CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [OP_W-1:0]   req_op,
   input  logic [DATA_W-1:0] req_operand,
   input  logic              req_load,
   input  logic              req_save,
   input  logic              req_restore,
   input  logic [CNT_W-1:0]  req_count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic              tmp_we,
   output logic              a_store,
   output logic              a_restore,
   output logic              cs,
   output logic [OP_W-1:0]   op
);

   typedef enum logic [2:0] {StIdle, StSave, StLoad, StExec, StRestore, StDone} state_e;

   localparam logic [OP_W-1:0] OpDaa = OP_W'(12);
   localparam logic [OP_W-1:0] OpMax = OP_W'(18);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [OP_W-1:0]     lat_op_q, lat_op_d;
   logic [DATA_W-1:0]   lat_operand_q, lat_operand_d;
   logic                lat_load_q, lat_load_d;
   logic                lat_save_q, lat_save_d;
   logic                lat_restore_q, lat_restore_d;
   logic                lat_illegal_q, lat_illegal_d;
   logic                req_illegal;

   assign req_illegal = (req_op == OpDaa) || (req_op > OpMax);

   // Next enabled step after 'cur'; an illegal op never enters EXEC.
   function automatic state_e step_after(input state_e cur, input logic save, input logic load,
                                         input logic illegal, input logic restore);
      if (cur == StIdle && save) return StSave;
      if ((cur == StIdle || cur == StSave) && load) return StLoad;
      if (cur != StExec && !illegal) return StExec;
      if (restore) return StRestore;
      return StDone;
   endfunction

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      lat_op_d      = lat_op_q;
      lat_operand_d = lat_operand_q;
      lat_load_d    = lat_load_q;
      lat_save_d    = lat_save_q;
      lat_restore_d = lat_restore_q;
      lat_illegal_d = lat_illegal_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               lat_op_d      = req_op;
               lat_operand_d = req_operand;
               lat_load_d    = req_load;
               lat_save_d    = req_save;
               lat_restore_d = req_restore;
               lat_illegal_d = req_illegal;
               cnt_d         = req_count;
               state_d       = step_after(StIdle, req_save, req_load, req_illegal, req_restore);
            end
         end
         StSave, StLoad: begin
            state_d = step_after(state_q, lat_save_q, lat_load_q, lat_illegal_q, lat_restore_q);
         end
         StExec: begin
            // Exit on zero rather than after wrap so a full-scale count gives 2^CNT_W cycles.
            if (cnt_q == '0) begin
               state_d = step_after(StExec, lat_save_q, lat_load_q, lat_illegal_q, lat_restore_q);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StRestore: state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so every strobe comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         lat_op_q      <= '0;
         lat_operand_q <= '0;
         lat_load_q    <= 1'b0;
         lat_save_q    <= 1'b0;
         lat_restore_q <= 1'b0;
         lat_illegal_q <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         bus_out       <= '0;
         bus_oe        <= 1'b0;
         tmp_we        <= 1'b0;
         a_store       <= 1'b0;
         a_restore     <= 1'b0;
         cs            <= 1'b0;
         op            <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         lat_op_q      <= lat_op_d;
         lat_operand_q <= lat_operand_d;
         lat_load_q    <= lat_load_d;
         lat_save_q    <= lat_save_d;
         lat_restore_q <= lat_restore_d;
         lat_illegal_q <= lat_illegal_d;
         busy          <= (state_d != StIdle);
         done          <= (state_d == StDone);
         err           <= (state_d == StDone) && lat_illegal_d;
         bus_out       <= (state_d == StLoad) ? lat_operand_d : '0;
         bus_oe        <= (state_d == StLoad);
         tmp_we        <= (state_d == StLoad);
         a_store       <= (state_d == StSave);
         a_restore     <= (state_d == StRestore);
         cs            <= (state_d == StExec);
         op            <= (state_d != StIdle) ? lat_op_d : '0;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: table of requests, per-cycle expected outputs queued at
// drive time and compared every cycle, plus done-latency checks.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [4:0] req_op;
   logic [7:0] req_operand;
   logic       req_load, req_save, req_restore;
   logic [2:0] req_count;
   logic       busy, done, err, bus_oe, tmp_we, a_store, a_restore, cs;
   logic [7:0] bus_out;
   logic [4:0] op;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       err;
      logic [7:0] bus_out;
      logic       bus_oe;
      logic       tmp_we;
      logic       a_store;
      logic       a_restore;
      logic       cs;
      logic [4:0] op;
   } out_t;

   typedef struct {
      logic [4:0] op;
      logic [7:0] operand;
      logic       load;
      logic       save;
      logic       restore;
      logic [2:0] count;
      int         exp_lat;
      int         poke1;
      int         poke2;
      int         rst_at;
   } vec_t;

   out_t   exp_q[$];
   out_t   act, mon_exp;
   int     checks = 0;
   int     errors = 0;
   bit     mon_en = 1'b0;
   vec_t   tbl[11];

   assign act = {busy, done, err, bus_out, bus_oe, tmp_we, a_store, a_restore, cs, op};

   always #5 clk = ~clk;

   alu_op_sequencer #(.DATA_W(8), .OP_W(5), .CNT_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .req_op      (req_op),
      .req_operand (req_operand),
      .req_load    (req_load),
      .req_save    (req_save),
      .req_restore (req_restore),
      .req_count   (req_count),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .bus_out     (bus_out),
      .bus_oe      (bus_oe),
      .tmp_we      (tmp_we),
      .a_store     (a_store),
      .a_restore   (a_restore),
      .cs          (cs),
      .op          (op)
   );

   // Compare every cycle on the falling edge; an empty queue means the DUT must be idle.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
         checks++;
         if (act !== mon_exp) begin
            errors++;
            $display("FAIL outputs t=%0t: got busy/done/err=%b%b%b bus=%h oe=%b tw=%b as=%b ar=%b cs=%b op=%h, expected busy/done/err=%b%b%b bus=%h oe=%b tw=%b as=%b ar=%b cs=%b op=%h",
                     $time, act.busy, act.done, act.err, act.bus_out, act.bus_oe, act.tmp_we,
                     act.a_store, act.a_restore, act.cs, act.op, mon_exp.busy, mon_exp.done,
                     mon_exp.err, mon_exp.bus_out, mon_exp.bus_oe, mon_exp.tmp_we,
                     mon_exp.a_store, mon_exp.a_restore, mon_exp.cs, mon_exp.op);
         end
         checks++;
         if ($countones({a_store, tmp_we, cs, a_restore}) > 1) begin
            errors++;
            $display("FAIL strobe_overlap t=%0t: got %b, required at most one set", $time,
                     {a_store, tmp_we, cs, a_restore});
         end
      end
   end

   // Expected per-cycle trace: an idle cycle before the start edge, then each enabled step.
   task automatic push_trace(input vec_t v);
      out_t t[$];
      out_t r, s;
      bit   ill;
      ill = (v.op == 5'h0C) || (v.op > 5'h12);
      r = '0;
      r.busy = 1'b1;
      r.op = v.op;
      if (v.save) begin s = r; s.a_store = 1'b1; t.push_back(s); end
      if (v.load) begin
         s = r; s.bus_oe = 1'b1; s.tmp_we = 1'b1; s.bus_out = v.operand; t.push_back(s);
      end
      if (!ill) begin
         for (int i = 0; i <= int'(v.count); i++) begin s = r; s.cs = 1'b1; t.push_back(s); end
      end
      if (v.restore) begin s = r; s.a_restore = 1'b1; t.push_back(s); end
      s = r; s.done = 1'b1; s.err = ill; t.push_back(s);
      exp_q.push_back('0);
      for (int i = 0; i < t.size(); i++) begin
         if (v.rst_at == 0 || i < v.rst_at) exp_q.push_back(t[i]);
      end
   endtask

   // Called just after a rising edge; returns just after a rising edge with start low.
   task automatic run_req(input vec_t v, input int idx);
      int g, lat;
      push_trace(v);
      req_op      = v.op;
      req_operand = v.operand;
      req_load    = v.load;
      req_save    = v.save;
      req_restore = v.restore;
      req_count   = v.count;
      start       = 1'b1;
      g   = 0;
      lat = 0;
      while (g < 300) begin
         @(posedge clk);
         g++;
         #1;
         if (done && lat == 0) lat = g;
         if (exp_q.size() == 0) begin
            start = 1'b0;
            rst   = 1'b0;
            break;
         end
         start = (g == v.poke1) || (g == v.poke2);
         if (start) begin
            req_op = 5'h01; req_operand = 8'hFF; req_load = 1'b1;
            req_save = 1'b1; req_restore = 1'b1; req_count = 3'd0;
         end
         rst = (g == v.rst_at);
      end
      checks++;
      if (g >= 300) begin
         errors++;
         $display("FAIL timeout vec%0d: got %0d cycles, required under 300", idx, g);
         exp_q.delete();
         start = 1'b0;
         rst   = 1'b0;
      end
      checks++;
      if (lat != v.exp_lat) begin
         errors++;
         $display("FAIL done_latency vec%0d: got %0d, required %0d", idx, lat, v.exp_lat);
      end
   endtask

   initial begin
      //          op     operand load  save  rest  count lat poke1 poke2 rst_at
      tbl[0]  = '{5'h00, 8'h3C, 1'b1, 1'b0, 1'b0, 3'd0, 3, 0, 0, 0};
      tbl[1]  = '{5'h08, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, 9, 0, 0, 0};
      tbl[2]  = '{5'h12, 8'h81, 1'b1, 1'b1, 1'b1, 3'd0, 5, 0, 0, 0};
      tbl[3]  = '{5'h0C, 8'h11, 1'b0, 1'b0, 1'b0, 3'd3, 1, 0, 0, 0};
      tbl[4]  = '{5'h17, 8'h22, 1'b1, 1'b0, 1'b0, 3'd0, 2, 0, 0, 0};
      tbl[5]  = '{5'h0C, 8'h33, 1'b0, 1'b1, 1'b1, 3'd5, 3, 0, 0, 0};
      tbl[6]  = '{5'h08, 8'h44, 1'b0, 1'b0, 1'b0, 3'd7, 9, 3, 9, 0};
      tbl[7]  = '{5'h03, 8'hA5, 1'b1, 1'b0, 1'b0, 3'd2, 5, 0, 0, 0};
      tbl[8]  = '{5'h08, 8'h55, 1'b0, 1'b0, 1'b0, 3'd7, 0, 0, 0, 3};
      tbl[9]  = '{5'h11, 8'h5A, 1'b1, 1'b1, 1'b0, 3'd1, 5, 0, 0, 0};
      tbl[10] = '{5'h13, 8'h66, 1'b0, 1'b0, 1'b1, 3'd4, 2, 0, 0, 0};

      rst = 1'b1; start = 1'b0; req_op = '0; req_operand = '0;
      req_load = 1'b0; req_save = 1'b0; req_restore = 1'b0; req_count = '0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++) run_req(tbl[i], i);
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
